regfile_dump: RTL and testbench

Sequential reader for the 16×8 general-purpose register file. On a `start` pulse it walks register addresses 0..NUM_REGS-1 through one register-file read port and streams each byte out on a valid/ready interface. The output feeds the debug/trace path. It drives the register file's `readAddress` input and consumes the matching combinational `readData`.

---
 rtl/regfile_dump.sv | 158 +++++++++++++++
 tb/tb_regfile_dump.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: sequential reader for a NUM_REGS x DATA_W register file.
// On a start pulse it walks addresses 0..NUM_REGS-1 through one combinational
// read port and streams each byte out on a valid/ready interface.
//
// Ports:
//   clk          in   clock, rising-edge
//   reset_n      in   asynchronous active-low reset
//   start        in   begin a dump (sampled only while idle)
//   readAddress  out  register-file read address
//   readData     in   register-file read data (combinational from readAddress)
//   outData      out  streamed byte
//   outValid     out  outData valid
//   outReady     in   sink accepts the byte
//   busy         out  dump in progress
//   done         out  one-cycle pulse after the last byte is accepted
//
// Build option: define REGDUMP_CHECKSUM_EN to append a modulo-2^DATA_W sum of
// all dumped bytes as one extra trailing byte.
module regfile_dump #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] readAddress,
  input  logic [DATA_W-1:0] readData,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    SUM  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  // SUM spends one cycle loading the checksum into the output register before
  // presenting it, keeping the trailing byte on the same 2-cycle cadence.
  logic                sum_vld_q, sum_vld_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
`ifdef REGDUMP_CHECKSUM_EN
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef REGDUMP_CHECKSUM_EN
    sum_d     = sum_q;
    sum_vld_d = sum_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      READ: begin
        data_d  = readData;
        state_d = SEND;
`ifdef REGDUMP_CHECKSUM_EN
        sum_d   = sum_q + readData;
`endif
      end
      SEND: begin
        if (outReady) begin
          if (cnt_q == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d   = SUM;
            sum_vld_d = 1'b0;
`else
            state_d   = DONE;
`endif
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      SUM: begin
        if (!sum_vld_q) begin
          data_d    = sum_q;
          sum_vld_d = 1'b1;
        end else if (outReady) begin
          state_d   = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    readAddress = cnt_q;
    outData     = data_q;
    outValid    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      READ: busy = 1'b1;
      SEND: begin
        busy     = 1'b1;
        outValid = 1'b1;
      end
`ifdef REGDUMP_CHECKSUM_EN
      SUM: begin
        busy     = 1'b1;
        outValid = sum_vld_q;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int NBYTES   = 17;
  localparam int DUMP_CYC = 34;
`else
  localparam int NBYTES   = 16;
  localparam int DUMP_CYC = 32;
`endif

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] readAddress;
  logic [7:0] readData;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       busy;
  logic       done;

  logic [7:0] regs [16];
  assign readData = regs[readAddress];

  regfile_dump #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .readAddress(readAddress), .readData(readData),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got   [0:39];
  logic [7:0] exp_b [0:39];
  int got_n, done_n, first_read, first_valid, done_at, unstable, busy_after;
  logic [3:0] addr_at_read;
  logic [7:0] rdy_pat [0:7];

  initial begin
    rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1;
    rdy_pat[4] = 1; rdy_pat[5] = 0; rdy_pat[6] = 1; rdy_pat[7] = 0;
  end

  task automatic preload();
    for (int i = 0; i < 16; i++) regs[i] = 8'(i * 8'h11);
  endtask

  task automatic fill_expected(input bit patched);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      exp_b[i] = 8'(i * 8'h11);
      if (patched && i == 5) exp_b[i] = 8'hAA;
      s += exp_b[i];
    end
    exp_b[16] = 8'(s);
  endtask

  // mode 0: ready high; 1: ready pattern; 2: writes at counter 2; 3: start during SEND
  task automatic run_dump(input int mode);
    bit prev_stall, wrote;
    logic [7:0] prev_data;
    got_n = 0; done_n = 0; first_read = -1; first_valid = -1; done_at = -1;
    unstable = 0; busy_after = 0; prev_stall = 0; wrote = 0; prev_data = '0;
    addr_at_read = 'x;
    @(posedge clk); #1;
    start = 1'b1;
    outReady = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      start = (mode == 3 && k == 3) ? 1'b1 : 1'b0;
      outReady = (mode == 1) ? rdy_pat[k % 8][0] : 1'b1;
      if (mode == 2 && !wrote && readAddress == 4'd2) begin
        regs[5] = 8'hAA;
        regs[1] = 8'h55;
        wrote = 1;
      end
      @(negedge clk);
      if (busy && first_read < 0) begin
        first_read = k;
        addr_at_read = readAddress;
      end
      if (outValid && first_valid < 0) first_valid = k;
      if (prev_stall && (!outValid || outData !== prev_data)) unstable++;
      prev_stall = outValid && !outReady;
      prev_data  = outData;
      if (outValid && outReady && got_n < 40) begin
        got[got_n] = outData;
        got_n++;
      end
      if (done_at >= 0 && (busy || outValid)) busy_after++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (done_at >= 0 && k >= done_at + 4) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; outReady = 1'b0;
    preload();
    repeat (3) @(negedge clk);
    checks++; if (readAddress !== 4'd0) begin errors++; $display("FAIL reset_addr got %h want 0", readAddress); end
    checks++; if (outData !== 8'd0) begin errors++; $display("FAIL reset_data got %h want 0", outData); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", outValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    preload();
    fill_expected(0);
    run_dump(0);
    checks++; if (first_read !== 0) begin errors++; $display("FAIL read_latency got %0d want 0", first_read); end
    checks++; if (addr_at_read !== 4'd0) begin errors++; $display("FAIL first_addr got %h want 0", addr_at_read); end
    checks++; if (first_valid - first_read !== 1) begin errors++; $display("FAIL valid_latency got %0d want 1", first_valid - first_read); end
    checks++; if (got_n !== NBYTES) begin errors++; $display("FAIL basic_count got %0d want %0d", got_n, NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, got[i], exp_b[i]); end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_n); end
    checks++; if (done_at - first_read !== DUMP_CYC) begin errors++; $display("FAIL basic_done_time got %0d want %0d", done_at - first_read, DUMP_CYC); end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL basic_idle_after got %0d want 0", busy_after); end
  endtask

  task automatic test_backpressure();
    preload();
    fill_expected(0);
    run_dump(1);
    checks++; if (got_n !== NBYTES) begin errors++; $display("FAIL bp_count got %0d want %0d", got_n, NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, got[i], exp_b[i]); end
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d want 0", unstable); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_n); end
  endtask

  task automatic test_live_write();
    preload();
    fill_expected(1);
    run_dump(2);
    checks++; if (got_n !== NBYTES) begin errors++; $display("FAIL lw_count got %0d want %0d", got_n, NBYTES); end
    checks++; if (got[5] !== 8'hAA) begin errors++; $display("FAIL lw_byte5 got %h want aa", got[5]); end
    checks++; if (got[1] !== 8'h11) begin errors++; $display("FAIL lw_byte1 got %h want 11", got[1]); end
`ifdef REGDUMP_CHECKSUM_EN
    checks++; if (got[16] !== exp_b[16]) begin errors++; $display("FAIL lw_sum got %h want %h", got[16], exp_b[16]); end
`endif
  endtask

  task automatic test_start_in_send();
    preload();
    fill_expected(0);
    run_dump(3);
    checks++; if (done_n !== 1) begin errors++; $display("FAIL sis_done_count got %0d want 1", done_n); end
    checks++; if (got_n !== NBYTES) begin errors++; $display("FAIL sis_count got %0d want %0d", got_n, NBYTES); end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL sis_restart got %0d want 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    int r1, r2, d1, d2, nbytes;
    bit prev_busy;
    r1 = -1; r2 = -1; d1 = -1; d2 = -1; nbytes = 0; prev_busy = 0;
    preload();
    @(posedge clk); #1;
    start = 1'b1;
    outReady = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
      end
      prev_busy = busy;
      if (outValid && outReady) nbytes++;
      if (done) begin
        if (d1 < 0) d1 = k;
        else begin
          d2 = k;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (d1 - r1 !== DUMP_CYC) begin errors++; $display("FAIL b2b_first_len got %0d want %0d", d1 - r1, DUMP_CYC); end
    checks++; if (r2 - d1 !== 2) begin errors++; $display("FAIL b2b_gap got %0d want 2", r2 - d1); end
    checks++; if (d2 - r2 !== DUMP_CYC) begin errors++; $display("FAIL b2b_second_len got %0d want %0d", d2 - r2, DUMP_CYC); end
    checks++; if (nbytes !== 2 * NBYTES) begin errors++; $display("FAIL b2b_bytes got %0d want %0d", nbytes, 2 * NBYTES); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_end got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_dump();
    bit reached;
    int bad;
    reached = 0; bad = 0;
    preload();
    fill_expected(0);
    @(posedge clk); #1;
    start = 1'b1;
    outReady = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (readAddress == 4'd7 && outValid) begin
        reached = 1;
        break;
      end
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL rst_reach_cnt7 got %b want 1", reached); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", outValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (readAddress !== 4'd0) begin errors++; $display("FAIL rst_mid_addr got %h want 0", readAddress); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || outValid || busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", bad); end
    run_dump(0);
    checks++; if (addr_at_read !== 4'd0) begin errors++; $display("FAIL rst_restart_addr got %h want 0", addr_at_read); end
    checks++; if (got_n !== NBYTES) begin errors++; $display("FAIL rst_restart_count got %0d want %0d", got_n, NBYTES); end
    checks++; if (got[0] !== exp_b[0] || got[15] !== exp_b[15]) begin errors++; $display("FAIL rst_restart_bytes got %h/%h want %h/%h", got[0], got[15], exp_b[0], exp_b[15]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_live_write();
    test_start_in_send();
    test_back_to_back();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
